// File: rtl/network_pkg.sv
// Shared packet/rule types and dispatcher state encoding for the classifier front end.
package network_pkg;

  typedef struct packed {
    logic [15:0] flow_id;
    logic [7:0]  proto;
    logic [15:0] dst_port;
  } packet_s;

  typedef struct packed {
    logic [31:0] weight;
    logic [11:0] rule_id;
    logic [3:0]  action;
  } rule_s;

  // Engine reports this weight when no rule in the tree matched.
  localparam logic [31:0] NO_MATCH_WEIGHT = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    HOLD
  } dispatch_state_e;

  function automatic logic [31:0] rule_weight(input rule_s r);
    return r.weight;
  endfunction

endpackage

// File: rtl/classifier_dispatcher_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, searching cyclically.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PORT_W-1:0]    grant_idx,
  output logic                 any_req
);

  logic              found;
  logic [PORT_W-1:0] cand;

  always_comb begin
    found     = 1'b0;
    cand      = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = PORT_W'((int'(ptr) + i) % NUM_PORTS);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign any_req = |req;
  assign grant   = any_req ? (NUM_PORTS'(1) << grant_idx) : '0;

endmodule

// File: rtl/classifier_dispatcher.sv
// Shares one tree-walk classifier engine between NUM_PORTS sources, one packet in flight.
// Optional walk watchdog and engine abort: define CLASSIFIER_DISPATCH_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for a request while the engine is ready
// ISSUE     | one-cycle eng_valid pulse with the latched packet
// WAIT_BUSY | waiting for the engine to drop ready (walk started)
// WAIT_DONE | waiting for the engine to raise ready (walk finished)
// HOLD      | result presented until res_ready
module classifier_dispatcher
  import network_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int PORT_W         = $clog2(NUM_PORTS),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_PORTS-1:0]    in_valid,
  output logic [NUM_PORTS-1:0]    in_ready,
  input  packet_s [NUM_PORTS-1:0] in_packet,
  output logic                    eng_valid,
  output packet_s                 eng_packet,
  input  logic                    eng_ready,
  input  rule_s                   eng_rule,
  output logic                    eng_abort,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [PORT_W-1:0]       res_port,
  output rule_s                   res_rule,
  output logic                    res_hit,
  output logic                    res_timeout
);

  dispatch_state_e   state, state_nxt;
  logic [PORT_W-1:0] rr_ptr;
  logic [PORT_W-1:0] grant_tag;
  packet_s           pkt_q;

  logic [NUM_PORTS-1:0] arb_grant;
  logic [PORT_W-1:0]    arb_idx;
  logic                 arb_any;

  logic accept;
  logic complete;
  logic timeout_hit;
  logic wd_expired;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

`ifdef CLASSIFIER_DISPATCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             res_timeout_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (state == ISSUE) begin
      wd_cnt <= '0;
    end else if ((state == WAIT_BUSY || state == WAIT_DONE) &&
                 (wd_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  assign wd_expired  = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign res_timeout = res_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign wd_expired         = 1'b0;
  assign res_timeout        = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    in_ready    = '0;
    eng_valid   = 1'b0;
    accept      = 1'b0;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any && eng_ready) begin
          in_ready  = arb_grant;
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        eng_valid = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (wd_expired) begin
          timeout_hit = 1'b1;
          state_nxt   = HOLD;
        end else if (!eng_ready) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // a walk finishing on the watchdog's last cycle still counts as done
        if (eng_ready) begin
          complete  = 1'b1;
          state_nxt = HOLD;
        end else if (wd_expired) begin
          timeout_hit = 1'b1;
          state_nxt   = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!reset_n) begin
      in_ready  = '0;
      eng_valid = 1'b0;
    end
  end

  assign eng_abort  = timeout_hit && reset_n;
  assign res_valid  = (state == HOLD) && reset_n;
  assign eng_packet = pkt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_tag <= '0;
      pkt_q     <= '0;
      res_port  <= '0;
      res_rule  <= '0;
      res_hit   <= 1'b0;
`ifdef CLASSIFIER_DISPATCH_TIMEOUT_EN
      res_timeout_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        pkt_q     <= in_packet[arb_idx];
        grant_tag <= arb_idx;
      end
      if (complete) begin
        res_port <= grant_tag;
        res_rule <= eng_rule;
        res_hit  <= (rule_weight(eng_rule) != NO_MATCH_WEIGHT);
`ifdef CLASSIFIER_DISPATCH_TIMEOUT_EN
        res_timeout_q <= 1'b0;
`endif
      end
      if (timeout_hit) begin
        res_port <= grant_tag;
        res_rule <= '0;
        res_hit  <= 1'b0;
`ifdef CLASSIFIER_DISPATCH_TIMEOUT_EN
        res_timeout_q <= 1'b1;
`endif
      end
      // pointer moves past the served port only once its result is taken
      if (state == HOLD && res_ready) begin
        rr_ptr <= (grant_tag == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_tag + PORT_W'(1);
      end
    end
  end

endmodule
